// File: rtl/stacking_pkg.sv
// Shared types and window arithmetic for the stacking outer-loop sequencer.
// STACKING_DRAIN_EN adds the accumulator-drain state to the state enum.
package stacking_pkg;

   // Width of the window arithmetic operands; one extra MSB acts as the borrow guard.
   localparam int unsigned WIN_W = 16;
   typedef logic [WIN_W:0] win_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_RUN    = 3'd2,
`ifdef STACKING_DRAIN_EN
      S_DRAIN  = 3'd3,
`endif
      S_DONE   = 3'd4
   } stk_ctrl_state_e;

   function automatic int unsigned out_size_y(input int unsigned ifm_size_y,
                                              input int unsigned fil_size_y);
      return ifm_size_y - fil_size_y + 1;
   endfunction

   // Index width that never collapses to zero bits for single-entry ranges.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // max(0, y - out_m1): a set guard bit after the subtraction means y < out_m1.
   function automatic win_t win_start(input win_t y, input win_t out_m1);
      win_t diff;
      diff = y - out_m1;
      return diff[WIN_W] ? '0 : diff;
   endfunction

   // min(fil_m1, y)
   function automatic win_t win_last(input win_t y, input win_t fil_m1);
      return (y > fil_m1) ? fil_m1 : y;
   endfunction

endpackage

// File: rtl/stacking_window_calc.sv
// Combinational valid filter-row window for a given IFM row.
module stacking_window_calc
   import stacking_pkg::*;
#(
   parameter int unsigned IFM_SIZE_Y = 5,
   parameter int unsigned FIL_SIZE_Y = 3,
   parameter int unsigned IDX_W      = 3
) (
   input  logic [IDX_W-1:0] y,
   output logic [IDX_W-1:0] win_start_c,
   output logic [IDX_W-1:0] win_last_c
);

   localparam int unsigned OUT_M1 = out_size_y(IFM_SIZE_Y, FIL_SIZE_Y) - 1;
   localparam int unsigned FIL_M1 = FIL_SIZE_Y - 1;

   win_t y_ext;
   win_t start_ext;
   win_t last_ext;

   assign y_ext     = (WIN_W+1)'(y);
   assign start_ext = win_start(y_ext, (WIN_W+1)'(OUT_M1));
   assign last_ext  = win_last(y_ext, (WIN_W+1)'(FIL_M1));

   assign win_start_c = IDX_W'(start_ext);
   assign win_last_c  = IDX_W'(last_ext);

endmodule

// File: rtl/stacking_outer_loop_ctrl.sv
// Outer-loop sequencer: walks IFM rows x channel chunks, launches the inner loop,
// and (with STACKING_DRAIN_EN defined) requests an accumulator drain per output row.
module stacking_outer_loop_ctrl
   import stacking_pkg::*;
#(
   parameter int unsigned IFM_SIZE_Y = 5,
   parameter int unsigned FIL_SIZE_Y = 3,
   parameter int unsigned FIL_SIZE_X = 3,
   parameter int unsigned CHUNK_NUM  = 2
) (
   input  logic                                                  clk_i,
   input  logic                                                  rst_i,
   input  logic                                                  start_i,
   input  logic                                                  abort_i,
   input  logic                                                  inner_loop_finish_i,
   input  logic                                                  drain_ready_i,
   output logic                                                  inner_loop_start_o,
   output logic [idx_w(IFM_SIZE_Y)-1:0]                          ifm_loop_y_idx_o,
   output logic [idx_w(IFM_SIZE_Y)-1:0]                          fil_loop_y_idx_start_o,
   output logic [idx_w(IFM_SIZE_Y)-1:0]                          fil_loop_y_idx_last_o,
   output logic [$clog2(FIL_SIZE_X+1)-1:0]                       fil_loop_y_step_o,
   output logic [idx_w(CHUNK_NUM)-1:0]                           chunk_idx_o,
   output logic                                                  drain_valid_o,
   output logic [idx_w(out_size_y(IFM_SIZE_Y, FIL_SIZE_Y))-1:0]  drain_row_o,
   output logic                                                  busy_o,
   output logic                                                  done_o
);

   localparam int unsigned OUT_SIZE_Y = out_size_y(IFM_SIZE_Y, FIL_SIZE_Y);
   localparam int unsigned YW         = idx_w(IFM_SIZE_Y);
   localparam int unsigned CW         = idx_w(CHUNK_NUM);
   localparam int unsigned DW         = idx_w(OUT_SIZE_Y);
   localparam int unsigned SW         = $clog2(FIL_SIZE_X + 1);

   localparam logic [YW-1:0] Y_LAST = YW'(IFM_SIZE_Y - 1);
   localparam logic [CW-1:0] C_LAST = CW'(CHUNK_NUM - 1);
`ifdef STACKING_DRAIN_EN
   localparam logic [YW-1:0] FIL_M1 = YW'(FIL_SIZE_Y - 1);
`endif

   stk_ctrl_state_e state_q, state_d;
   logic [YW-1:0]   y_q, y_d;
   logic [CW-1:0]   c_q, c_d;
   logic [YW-1:0]   win_start_q, win_last_q;
   logic [YW-1:0]   win_start_c, win_last_c;
   logic            start_pulse_q;
   logic            busy_q;
   logic            done_q;

   // Window is evaluated on the row that the next LAUNCH will use.
   stacking_window_calc #(
      .IFM_SIZE_Y (IFM_SIZE_Y),
      .FIL_SIZE_Y (FIL_SIZE_Y),
      .IDX_W      (YW)
   ) u_window_calc (
      .y           (y_d),
      .win_start_c (win_start_c),
      .win_last_c  (win_last_c)
   );

`ifdef STACKING_DRAIN_EN
   logic [DW-1:0] drain_row_q, drain_row_d;
   logic          drain_valid_q;
`else
   logic          unused_drain_ready;
   assign unused_drain_ready = drain_ready_i;
`endif

   // Next-state, row and chunk sequencing; abort overrides everything.
   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      c_d     = c_q;
`ifdef STACKING_DRAIN_EN
      drain_row_d = drain_row_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_LAUNCH;
               y_d     = '0;
               c_d     = '0;
            end
         end
         S_LAUNCH: state_d = S_RUN;
         S_RUN: begin
            if (inner_loop_finish_i) begin
               if (c_q != C_LAST) begin
                  c_d     = c_q + CW'(1);
                  state_d = S_LAUNCH;
               end
`ifdef STACKING_DRAIN_EN
               else if (y_q >= FIL_M1) begin
                  drain_row_d = DW'(y_q - FIL_M1);
                  state_d     = S_DRAIN;
               end
`endif
               else if (y_q == Y_LAST) begin
                  state_d = S_DONE;
               end else begin
                  y_d     = y_q + YW'(1);
                  c_d     = '0;
                  state_d = S_LAUNCH;
               end
            end
         end
`ifdef STACKING_DRAIN_EN
         S_DRAIN: begin
            if (drain_ready_i) begin
               if (y_q == Y_LAST) begin
                  state_d = S_DONE;
               end else begin
                  y_d     = y_q + YW'(1);
                  c_d     = '0;
                  state_d = S_LAUNCH;
               end
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
            y_d     = '0;
            c_d     = '0;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort_i) begin
         state_d = S_IDLE;
         y_d     = '0;
         c_d     = '0;
      end
   end

   // State, counters and registered outputs decoded from the next state.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q       <= S_IDLE;
         y_q           <= '0;
         c_q           <= '0;
         win_start_q   <= '0;
         win_last_q    <= '0;
         start_pulse_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         y_q           <= y_d;
         c_q           <= c_d;
         start_pulse_q <= (state_d == S_LAUNCH);
         busy_q        <= (state_d != S_IDLE);
         done_q        <= (state_d == S_DONE);
         if (state_d == S_LAUNCH) begin
            win_start_q <= win_start_c;
            win_last_q  <= win_last_c;
         end
      end
   end

`ifdef STACKING_DRAIN_EN
   // Drain request stays up with a frozen row until the handshake edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         drain_valid_q <= 1'b0;
         drain_row_q   <= '0;
      end else begin
         drain_valid_q <= (state_d == S_DRAIN);
         drain_row_q   <= drain_row_d;
      end
   end

   assign drain_valid_o = drain_valid_q;
   assign drain_row_o   = drain_row_q;
`else
   assign drain_valid_o = 1'b0;
   assign drain_row_o   = '0;
`endif

   assign inner_loop_start_o     = start_pulse_q;
   assign ifm_loop_y_idx_o       = y_q;
   assign chunk_idx_o            = c_q;
   assign fil_loop_y_idx_start_o = win_start_q;
   assign fil_loop_y_idx_last_o  = win_last_q;
   assign fil_loop_y_step_o      = SW'(FIL_SIZE_X);
   assign busy_o                 = busy_q;
   assign done_o                 = done_q;

endmodule

// File: tb/tb_stacking_outer_loop_ctrl.sv
// Scoreboard bench for stacking_outer_loop_ctrl (default parameters); the model
// follows STACKING_DRAIN_EN so the same bench serves both builds.
module tb_stacking_outer_loop_ctrl;

   localparam int IFM = 5;
   localparam int FIL = 3;
   localparam int FILX = 3;
   localparam int CH  = 2;
   localparam int OUT = IFM - FIL + 1;
`ifdef STACKING_DRAIN_EN
   localparam bit DRAIN_EN = 1'b1;
`else
   localparam bit DRAIN_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_i = 1'b0;
   logic       start_i = 1'b0;
   logic       abort_i = 1'b0;
   logic       inner_loop_finish_i = 1'b0;
   logic       drain_ready_i = 1'b0;
   logic       inner_loop_start_o;
   logic [2:0] ifm_loop_y_idx_o;
   logic [2:0] fil_loop_y_idx_start_o;
   logic [2:0] fil_loop_y_idx_last_o;
   logic [1:0] fil_loop_y_step_o;
   logic [0:0] chunk_idx_o;
   logic       drain_valid_o;
   logic [1:0] drain_row_o;
   logic       busy_o;
   logic       done_o;

   stacking_outer_loop_ctrl #(
      .IFM_SIZE_Y (IFM),
      .FIL_SIZE_Y (FIL),
      .FIL_SIZE_X (FILX),
      .CHUNK_NUM  (CH)
   ) dut (
      .clk_i                  (clk),
      .rst_i                  (rst_i),
      .start_i                (start_i),
      .abort_i                (abort_i),
      .inner_loop_finish_i    (inner_loop_finish_i),
      .drain_ready_i          (drain_ready_i),
      .inner_loop_start_o     (inner_loop_start_o),
      .ifm_loop_y_idx_o       (ifm_loop_y_idx_o),
      .fil_loop_y_idx_start_o (fil_loop_y_idx_start_o),
      .fil_loop_y_idx_last_o  (fil_loop_y_idx_last_o),
      .fil_loop_y_step_o      (fil_loop_y_step_o),
      .chunk_idx_o            (chunk_idx_o),
      .drain_valid_o          (drain_valid_o),
      .drain_row_o            (drain_row_o),
      .busy_o                 (busy_o),
      .done_o                 (done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int y;
      int c;
      int ws;
      int wl;
   } launch_t;

   launch_t exp_launch[$];
   int      exp_drain[$];
   int      exp_done[$];
   int      checks = 0;
   int      failures = 0;
   bit      start_real = 1'b0;
   bit      fin_real = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference sequence of one layer from the loop-nest definition.
   function automatic void build_expected(input int abort_y);
      launch_t e;
      exp_launch.delete();
      exp_drain.delete();
      exp_done.delete();
      for (int y = 0; y < IFM; y++) begin
         for (int c = 0; c < CH; c++) begin
            e.y  = y;
            e.c  = c;
            e.ws = (y - (OUT - 1) > 0) ? y - (OUT - 1) : 0;
            e.wl = (y < FIL - 1) ? y : FIL - 1;
            exp_launch.push_back(e);
            if (y == abort_y && c == CH - 1) return;
         end
         if (DRAIN_EN && y >= FIL - 1) exp_drain.push_back(y - (FIL - 1));
      end
      exp_done.push_back(1);
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_start"}, int'(inner_loop_start_o), 0);
      check({tag, "_y"}, int'(ifm_loop_y_idx_o), 0);
      check({tag, "_win"}, int'({fil_loop_y_idx_start_o, fil_loop_y_idx_last_o}), 0);
      check({tag, "_step"}, int'(fil_loop_y_step_o), FILX);
      check({tag, "_chunk"}, int'(chunk_idx_o), 0);
      check({tag, "_drain"}, int'({drain_valid_o, drain_row_o}), 0);
      check({tag, "_busy_done"}, int'({busy_o, done_o}), 0);
   endtask

   // Monitor: samples just after the driver updates inputs on the falling edge.
   bit      prev_dv, prev_dr, prev_done, prev_start, prev_fin;
   int      prev_row;
   launch_t got;
   initial begin
      prev_dv = 0; prev_dr = 0; prev_done = 0; prev_start = 0; prev_fin = 0; prev_row = 0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_i) begin
            prev_dv = 0; prev_dr = 0; prev_done = 0; prev_start = 0; prev_fin = 0;
         end else begin
            if (inner_loop_start_o) begin
               check("launch_expected", int'(exp_launch.size() > 0), 1);
               check("launch_during_drain", int'(drain_valid_o), 0);
               if (exp_launch.size() > 0) begin
                  got = exp_launch.pop_front();
                  check("launch_y", int'(ifm_loop_y_idx_o), got.y);
                  check("launch_chunk", int'(chunk_idx_o), got.c);
                  check("launch_win_start", int'(fil_loop_y_idx_start_o), got.ws);
                  check("launch_win_last", int'(fil_loop_y_idx_last_o), got.wl);
               end
            end
            if (drain_valid_o && drain_ready_i) begin
               check("drain_expected", int'(exp_drain.size() > 0), 1);
               if (exp_drain.size() > 0) check("drain_row", int'(drain_row_o), exp_drain.pop_front());
            end
            if (prev_dv && !prev_dr) begin
               check("drain_hold_valid", int'(drain_valid_o), 1);
               check("drain_row_stable", int'(drain_row_o), prev_row);
            end
            if (done_o) begin
               check("done_expected", int'(exp_done.size() > 0), 1);
               if (exp_done.size() > 0) void'(exp_done.pop_front());
               check("done_launch_left", exp_launch.size(), 0);
               check("done_drain_left", exp_drain.size(), 0);
               check("done_busy", int'(busy_o), 1);
            end
            if (prev_done) check("busy_after_done", int'(busy_o), 0);
            if (prev_start) check("start_latency", int'(inner_loop_start_o), 1);
            if (prev_fin)
               check("finish_response", int'(inner_loop_start_o || drain_valid_o || done_o), 1);
            check("step_const", int'(fil_loop_y_step_o), FILX);
            prev_dv    = drain_valid_o;
            prev_dr    = drain_ready_i;
            prev_row   = int'(drain_row_o);
            prev_done  = done_o;
            prev_start = start_real;
            prev_fin   = fin_real;
         end
      end
   end

   // Driver: responds to launches with finish pulses, randomizes drain ready.
   task automatic run_layer(input int abort_y, input bit hold_rdy, input bit noise, input bit do_reset);
      int fin_cnt, hold_left;
      bit finished, aborted, hold_used, rst_point;
      build_expected(abort_y);
      fin_cnt = 0; hold_left = 0; finished = 0; aborted = 0; hold_used = 0;
      @(negedge clk);
      start_i = 1'b1; start_real = 1'b1;
      for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
         @(negedge clk);
         start_i = 1'b0; start_real = 1'b0; fin_real = 1'b0;
         abort_i = 1'b0; inner_loop_finish_i = 1'b0;
         drain_ready_i = 1'($urandom_range(1, 0));
         if (aborted) begin
            check("abort_busy", int'(busy_o), 0);
            check("abort_y_cleared", int'(ifm_loop_y_idx_o), 0);
            check("abort_c_cleared", int'(chunk_idx_o), 0);
            finished = 1;
         end else if (done_o) begin
            finished = 1;
         end else begin
            if (inner_loop_start_o) begin
               fin_cnt = $urandom_range(4, 1);
               if (noise && $urandom_range(1, 0) == 1) inner_loop_finish_i = 1'b1;
            end else if (fin_cnt > 0) begin
               fin_cnt--;
               if (fin_cnt == 0) begin
                  inner_loop_finish_i = 1'b1;
                  if (abort_y == int'(ifm_loop_y_idx_o) && int'(chunk_idx_o) == CH - 1) begin
                     abort_i = 1'b1;
                     aborted = 1;
                  end else begin
                     fin_real = 1'b1;
                  end
               end
            end
            if (noise && busy_o && !inner_loop_finish_i && $urandom_range(5, 0) == 0) start_i = 1'b1;
            if (drain_valid_o) begin
               if (hold_rdy && !hold_used) begin
                  hold_used = 1;
                  hold_left = 7;
               end
               if (hold_left > 0) begin
                  hold_left--;
                  drain_ready_i = 1'b0;
               end
            end
            rst_point = DRAIN_EN ? drain_valid_o
                                 : (busy_o && !inner_loop_start_o && ifm_loop_y_idx_o == 3'd2);
            if (do_reset && rst_point) begin
               drain_ready_i = 1'b0; inner_loop_finish_i = 1'b0; fin_real = 1'b0; start_i = 1'b0;
               #2 rst_i = 1'b0;
               #1 check_reset_vals("async_rst");
               exp_launch.delete(); exp_drain.delete(); exp_done.delete();
               repeat (2) @(negedge clk);
               rst_i = 1'b1;
               finished = 1;
            end
         end
      end
      check("layer_completed", int'(finished), 1);
      start_i = 1'b0; abort_i = 1'b0; inner_loop_finish_i = 1'b0; fin_real = 1'b0;
      repeat (3) @(negedge clk);
      check("launch_left", exp_launch.size(), 0);
      check("drain_left", exp_drain.size(), 0);
      check("done_left", exp_done.size(), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      rst_i = 1'b1;
      repeat (2) @(negedge clk);
      run_layer(-1, 1'b0, 1'b0, 1'b0);
      run_layer(-1, 1'b1, 1'b1, 1'b0);
      run_layer(3, 1'b0, 1'b0, 1'b0);
      run_layer(-1, 1'b0, 1'b0, 1'b0);
      run_layer(-1, 1'b0, 1'b0, 1'b1);
      run_layer(-1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) run_layer(-1, 1'b0, 1'b1, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
